// File: rtl/token_ring_pkg.sv
// Shared constants, occupancy typedef and popcount helper for the token ring.
package token_ring_pkg;

   localparam int unsigned STAGES_DEF = 14;
   localparam int unsigned POP_MAX    = 64;

   typedef logic [STAGES_DEF-1:0] occ_t;

   localparam occ_t INIT_OCC_DEF = 14'b00000000000101;

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned n = 0;
      for (int unsigned i = 0; i < POP_MAX; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/token_ring_if.sv
// Control/status bundle between board I/O, the token ring and the display logic.
interface token_ring_if
   import token_ring_pkg::*;
#(
   parameter int unsigned STAGES = STAGES_DEF,
   parameter int unsigned DIV_W  = 24,
   parameter int unsigned CNT_W  = $clog2(STAGES + 1)
) ();

   logic             run;
   logic             step;
   logic             inject;
   logic             remove;
   logic [DIV_W-1:0] div;
   logic [STAGES-1:0] occ;
   logic [CNT_W-1:0] tokens;
   logic             tick_o;
   logic             inject_busy;
   logic             remove_busy;
   logic             deadlock;
   logic             empty;

   modport master (
      output run, step, inject, remove, div,
      input  occ, tokens, tick_o, inject_busy, remove_busy, deadlock, empty
   );

   modport slave (
      input  run, step, inject, remove, div,
      output occ, tokens, tick_o, inject_busy, remove_busy, deadlock, empty
   );

endinterface

// File: rtl/token_ring_tick_gen.sv
// Advance strobe: free-running divider or single-step edge detector, plus registered copy.
module tick_gen #(
   parameter int unsigned DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt;
   logic             stepPrev;

   always_comb begin
      tick = run ? (cnt == div) : (step & ~stepPrev);
   end

   // step is sampled during reset as well, so a level held across reset is never seen as an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         stepPrev <= step;
         tick_o   <= 1'b0;
      end else begin
         stepPrev <= step;
         tick_o   <= tick;
         if (!run || tick) cnt <= '0;
         else              cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/token_ring.sv
// Clocked token ring: bubble-rule advance, pending inject at stage 0, pending remove at the last stage.
module token_ring
   import token_ring_pkg::*;
#(
   parameter int unsigned       STAGES   = STAGES_DEF,
   parameter logic [STAGES-1:0] INIT_OCC = STAGES'(INIT_OCC_DEF),
   parameter int unsigned       DIV_W    = 24,
   parameter int unsigned       CNT_W    = $clog2(STAGES + 1)
) (
   input logic         clk,
   input logic         rst_n,
   token_ring_if.slave ring
);

   localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(popcount(64'(INIT_OCC)));

   logic              tick;
   logic [STAGES-1:0] occQ, occNext, mv, mvIn;
   logic [CNT_W-1:0]  tokensQ, tokensNext;
   logic              injBusy, remBusy;
   logic              removing, entering, accept;

   tick_gen #(.DIV_W(DIV_W)) uTickGen (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (ring.run),
      .step   (ring.step),
      .div    (ring.div),
      .tick   (tick),
      .tick_o (ring.tick_o)
   );

   // The leaving token is deleted instead of wrapping, so it neither fills stage 0 nor blocks an inject.
   always_comb begin
      mv = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         mv[i] = occQ[i] & ~occQ[(i + 1) % STAGES];
      end
      removing = tick & remBusy & occQ[STAGES-1];
      entering = occQ[STAGES-1] & ~removing;
      accept   = tick & injBusy & ~occQ[0] & ~entering;
      mvIn     = mv;
      if (removing) mvIn[STAGES-1] = 1'b0;

      occNext = occQ;
      if (tick) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            occNext[i] = (occQ[i] & ~mv[i]) | mvIn[(i + STAGES - 1) % STAGES];
         end
         if (removing) occNext[STAGES-1] = 1'b0;
         if (accept)   occNext[0]        = 1'b1;
      end

      tokensNext = tokensQ;
      if (accept && !removing)      tokensNext = tokensQ + CNT_W'(1);
      else if (removing && !accept) tokensNext = tokensQ - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occQ    <= INIT_OCC;
         tokensQ <= INIT_CNT;
         injBusy <= 1'b0;
         remBusy <= 1'b0;
      end else begin
         occQ    <= occNext;
         tokensQ <= tokensNext;
         injBusy <= injBusy ? ~accept   : ring.inject;
         remBusy <= remBusy ? ~removing : ring.remove;
      end
   end

   assign ring.occ         = occQ;
   assign ring.tokens      = tokensQ;
   assign ring.inject_busy = injBusy;
   assign ring.remove_busy = remBusy;
   assign ring.deadlock    = &occQ;
   assign ring.empty       = ~|occQ;

   tokenCountMatchesOcc: assert property (
      @(posedge clk) disable iff (!rst_n) tokensQ == CNT_W'(popcount(64'(occQ)))
   );

endmodule
